// File: rtl/fetch_pkg.sv
// Shared types, default sizes and the PC wrap helper for the instruction fetch queue.
package fetch_pkg;
  localparam int unsigned IW_DEF = 32;
  localparam int unsigned N_DEF  = 512;
  localparam int unsigned AW_DEF = $clog2(N_DEF);

  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [IW_DEF-1:0] instr;
  } fetch_entry_t;

  // Next word address, wrapping from n-1 back to 0 for non power-of-two memories.
  function automatic logic [31:0] pc_next(input logic [31:0] pc, input int unsigned n);
    return (pc == 32'(n - 1)) ? 32'd0 : pc + 32'd1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} entries; flush drops all contents.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = $bits(fetch_entry_t),
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching instruction fetch unit with PC-tagged buffer and redirect/discard handling.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned N     = N_DEF,
  parameter  int unsigned IW    = IW_DEF,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(N),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          FETCH_EN,
  input  logic          REDIR_VALID,
  input  logic [AW-1:0] REDIR_PC,
  output logic          MEM_REQ_VALID,
  input  logic          MEM_REQ_READY,
  output logic [AW-1:0] MEM_REQ_ADDR,
  input  logic          MEM_RSP_VALID,
  input  logic [IW-1:0] MEM_RSP_DATA,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   PERF_FETCHED,
  output logic [31:0]   PERF_STALL,
  output logic [15:0]   PERF_FLUSH,
`endif
  output logic          INSTR_VALID,
  input  logic          INSTR_READY,
  output logic [IW-1:0] INSTR,
  output logic [AW-1:0] INSTR_PC
);
  localparam int unsigned SW = CW + 1;

  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_rsp_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_discard;
  logic [CW-1:0]    w_count;
  logic [AW+IW-1:0] w_head;
  logic             w_credit;
  logic             w_req_fire;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_out_after_rsp;

  // Buffered plus in-flight words may never exceed the buffer size.
  assign w_credit        = ({1'b0, w_count} + {1'b0, r_outstanding}) < SW'(DEPTH);
  assign MEM_REQ_VALID   = FETCH_EN && w_credit && !REDIR_VALID && !RSTN;
  assign MEM_REQ_ADDR    = r_pc;
  assign w_req_fire      = MEM_REQ_VALID && MEM_REQ_READY;
  assign w_rsp           = MEM_RSP_VALID && (r_outstanding != '0);
  assign w_push          = w_rsp && (r_discard == '0) && !REDIR_VALID;
  assign w_pop           = INSTR_VALID && INSTR_READY && !REDIR_VALID;
  assign w_out_after_rsp = r_outstanding - CW'(w_rsp);

  fetch_fifo #(.DEPTH(DEPTH), .W(AW + IW)) u_fifo (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(REDIR_VALID),
    .i_data ({r_rsp_pc, MEM_RSP_DATA}),
    .o_count(w_count),
    .o_head (w_head)
  );

  assign INSTR_VALID     = (w_count != '0);
  assign {INSTR_PC, INSTR} = w_head;

  // Redirect turns every word still in flight into one to be discarded.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      r_pc          <= '0;
      r_rsp_pc      <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (REDIR_VALID) begin
      r_pc          <= REDIR_PC;
      r_rsp_pc      <= REDIR_PC;
      r_outstanding <= w_out_after_rsp;
      r_discard     <= w_out_after_rsp;
    end else begin
      if (w_req_fire) r_pc <= AW'(pc_next(32'(r_pc), N));
      if (w_push) r_rsp_pc <= AW'(pc_next(32'(r_rsp_pc), N));
      r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
      if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
    end
  end

  a_no_stray_rsp: assert property (@(posedge CLK) disable iff (RSTN)
    !(MEM_RSP_VALID && (r_outstanding == '0)));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_flush;

  // Saturating event counters.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_flush   <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (INSTR_READY && !INSTR_VALID && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (REDIR_VALID && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign PERF_FETCHED = r_perf_fetched;
  assign PERF_STALL   = r_perf_stall;
  assign PERF_FLUSH   = r_perf_flush;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed phases plus random traffic against a request/epoch model.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned AW    = AW_DEF;
  localparam int unsigned IW    = IW_DEF;
  localparam int unsigned DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          FETCH_EN;
  logic          REDIR_VALID;
  logic [AW-1:0] REDIR_PC;
  logic          MEM_REQ_VALID;
  logic          MEM_REQ_READY;
  logic [AW-1:0] MEM_REQ_ADDR;
  logic          MEM_RSP_VALID;
  logic [IW-1:0] MEM_RSP_DATA;
  logic          INSTR_VALID;
  logic          INSTR_READY;
  logic [IW-1:0] INSTR;
  logic [AW-1:0] INSTR_PC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   PERF_FETCHED;
  logic [31:0]   PERF_STALL;
  logic [15:0]   PERF_FLUSH;
`endif

  instr_fetch_queue #(.N(N_DEF), .IW(IW), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .FETCH_EN     (FETCH_EN),
    .REDIR_VALID  (REDIR_VALID),
    .REDIR_PC     (REDIR_PC),
    .MEM_REQ_VALID(MEM_REQ_VALID),
    .MEM_REQ_READY(MEM_REQ_READY),
    .MEM_REQ_ADDR (MEM_REQ_ADDR),
    .MEM_RSP_VALID(MEM_RSP_VALID),
    .MEM_RSP_DATA (MEM_RSP_DATA),
`ifdef FETCH_PERF_CNT_EN
    .PERF_FETCHED (PERF_FETCHED),
    .PERF_STALL   (PERF_STALL),
    .PERF_FLUSH   (PERF_FLUSH),
`endif
    .INSTR_VALID  (INSTR_VALID),
    .INSTR_READY  (INSTR_READY),
    .INSTR        (INSTR),
    .INSTR_PC     (INSTR_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    int            epoch;
  } req_t;

  req_t          mem_q[$];
  fetch_entry_t  m_q[$];
  logic [AW-1:0] dut_pops[$];
  logic [AW-1:0] m_pc;
  int            epoch;
  int            cyc;
  int            lat;
  int            n_chk;
  int            n_pass;
  int            n_req_dut;
  bit            found;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] p);
    return AW'((int'(p) + 1) % int'(N_DEF));
  endfunction

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model to the next posedge.
  task automatic step(input bit fe, input bit redir, input logic [AW-1:0] rpc,
                      input bit mrdy, input bit irdy);
    bit           rsp_now;
    bit           exp_rv;
    bit           pop;
    bit           keep;
    req_t         r;
    req_t         nr;
    fetch_entry_t e;
    @(negedge CLK);
    FETCH_EN      = fe;
    REDIR_VALID   = redir;
    REDIR_PC      = rpc;
    MEM_REQ_READY = mrdy;
    INSTR_READY   = irdy;
    rsp_now       = (mem_q.size() != 0) && (mem_q[0].due == cyc);
    MEM_RSP_VALID = rsp_now;
    if (rsp_now) MEM_RSP_DATA = mem_word(mem_q[0].addr);
    else         MEM_RSP_DATA = $urandom;
    #1;
    if (RSTN) begin
      chk("rst_instr_valid", 64'(INSTR_VALID), 64'(0));
      chk("rst_instr", 64'(INSTR), 64'(0));
      chk("rst_instr_pc", 64'(INSTR_PC), 64'(0));
      chk("rst_req_valid", 64'(MEM_REQ_VALID), 64'(0));
      if (rsp_now) mem_q.delete(0);
    end else begin
      exp_rv = fe && !redir && ((m_q.size() + mem_q.size()) < DEPTH);
      chk("instr_valid", 64'(INSTR_VALID), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("instr_pc", 64'(INSTR_PC), 64'(m_q[0].pc));
        chk("instr", 64'(INSTR), 64'(m_q[0].instr));
      end
      chk("req_valid", 64'(MEM_REQ_VALID), 64'(exp_rv));
      if (exp_rv) chk("req_addr", 64'(MEM_REQ_ADDR), 64'(m_pc));
      if (MEM_REQ_VALID && MEM_REQ_READY) n_req_dut++;
      if (INSTR_VALID && INSTR_READY && !redir) dut_pops.push_back(INSTR_PC);
      pop  = !redir && irdy && (m_q.size() != 0);
      keep = 1'b0;
      if (rsp_now) begin
        r = mem_q.pop_front();
        keep = !redir && (r.epoch == epoch);
      end
      if (redir) begin
        m_q.delete();
        epoch++;
        m_pc = rpc;
      end else begin
        if (pop) m_q.delete(0);
        if (keep) begin
          e.pc    = r.addr;
          e.instr = mem_word(r.addr);
          m_q.push_back(e);
        end
        if (exp_rv && mrdy) begin
          nr.due   = cyc + lat;
          nr.addr  = m_pc;
          nr.epoch = epoch;
          mem_q.push_back(nr);
          m_pc = wrap(m_pc);
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit fe, input bit mrdy, input bit irdy);
    for (int i = 0; i < n; i++) step(fe, 1'b0, '0, mrdy, irdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 24 && (mem_q.size() != 0 || m_q.size() != 0); i++)
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  // Asynchronous reset in the middle of a high clock phase, held past the memory latency.
  task automatic do_reset();
    @(posedge CLK);
    #2;
    RSTN = 1'b1;
    #1;
    chk("async_instr_valid", 64'(INSTR_VALID), 64'(0));
    chk("async_instr", 64'(INSTR), 64'(0));
    chk("async_instr_pc", 64'(INSTR_PC), 64'(0));
    chk("async_req_valid", 64'(MEM_REQ_VALID), 64'(0));
    m_q.delete();
    m_pc = '0;
    epoch++;
    for (int i = 0; i < lat + 2; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    @(posedge CLK);
    #1;
    RSTN = 1'b0;
  endtask

  initial begin
    RSTN = 1'b1; FETCH_EN = 1'b0; REDIR_VALID = 1'b0; REDIR_PC = '0;
    MEM_REQ_READY = 1'b0; MEM_RSP_VALID = 1'b0; MEM_RSP_DATA = '0; INSTR_READY = 1'b0;
    m_pc = '0; epoch = 0; cyc = 0; lat = 2; n_chk = 0; n_pass = 0; n_req_dut = 0;

    run(2, 1'b1, 1'b1, 1'b1);
    @(posedge CLK);
    #1;
    RSTN = 1'b0;

    // Streaming fetch from PC 0.
    dut_pops.delete();
    run(30, 1'b1, 1'b1, 1'b1);
    chk("stream_pop_cnt", 64'(dut_pops.size() >= 20), 64'(1));
    for (int i = 0; i < 8 && i < dut_pops.size(); i++) chk("stream_pc", 64'(dut_pops[i]), 64'(i));

    // Decode stalled: exactly DEPTH requests, then resume after first pop.
    do_reset();
    n_req_dut = 0;
    run(10, 1'b1, 1'b1, 1'b0);
    chk("stall_req_cnt", 64'(n_req_dut), 64'(DEPTH));
    chk("stall_valid", 64'(INSTR_VALID), 64'(1));
    chk("stall_pc", 64'(INSTR_PC), 64'(0));
    run(1, 1'b1, 1'b1, 1'b1);
    n_req_dut = 0;
    run(1, 1'b1, 1'b1, 1'b0);
    chk("resume_req", 64'(n_req_dut), 64'(1));

    // Redirect with three responses in flight.
    drain();
    lat = 4;
    run(3, 1'b1, 1'b1, 1'b1);
    chk("inflight3", 64'(n_req_dut >= 4), 64'(1));
    step(1'b1, 1'b1, AW'(9'h100), 1'b1, 1'b1);
    dut_pops.delete();
    run(1, 1'b1, 1'b1, 1'b1);
    chk("flushed", 64'(INSTR_VALID), 64'(0));
    run(15, 1'b1, 1'b1, 1'b1);
    chk("redir_first_pc", 64'((dut_pops.size() != 0) ? dut_pops[0] : AW'('x)), 64'(9'h100));

    // Redirect coinciding with a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_q.size() != 0 && mem_q[0].due == cyc && m_q.size() != 0) found = 1'b1;
      else step(1'b1, 1'b0, '0, 1'b1, ($urandom % 3) == 0);
    end
    chk("found_rsp_pop", 64'(found), 64'(1));
    step(1'b1, 1'b1, AW'(9'h040), 1'b1, 1'b1);
    run(1, 1'b1, 1'b1, 1'b1);
    chk("flushed2", 64'(INSTR_VALID), 64'(0));
    run(20, 1'b1, 1'b1, 1'b1);

    // PC wrap from N-1 to 0.
    drain();
    lat = 2;
    step(1'b1, 1'b1, AW'(N_DEF - 1), 1'b1, 1'b1);
    dut_pops.delete();
    run(10, 1'b1, 1'b1, 1'b1);
    chk("wrap_pop_cnt", 64'(dut_pops.size() >= 2), 64'(1));
    chk("wrap_pc0", 64'((dut_pops.size() > 0) ? dut_pops[0] : AW'('x)), 64'(N_DEF - 1));
    chk("wrap_pc1", 64'((dut_pops.size() > 1) ? dut_pops[1] : AW'('x)), 64'(0));

    // Random traffic with occasional redirects.
    drain();
    lat = 3;
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 20) == 0, AW'($urandom),
           ($urandom % 4) != 0, ($urandom % 3) != 0);

    // Reset mid-stream with two requests outstanding.
    drain();
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, 1'b1);
      if (mem_q.size() == 2) found = 1'b1;
    end
    chk("found_two_outstanding", 64'(found), 64'(1));
    do_reset();
    dut_pops.delete();
    run(10, 1'b1, 1'b1, 1'b1);
    chk("restart_pc", 64'((dut_pops.size() != 0) ? dut_pops[0] : AW'('x)), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
